// File: rtl/kwan_decode_pkg.sv
// Shared encodings and the decoded-instruction payload for the kwanCPU decode stage.
// The immediate is carried at the widest XLEN; narrower stages use its low bits.
package kwan_decode_pkg;

  localparam int unsigned IMM_MAX_W = 64;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;

  localparam logic [1:0] A_SRC_RS1  = 2'd0;
  localparam logic [1:0] A_SRC_PC   = 2'd1;
  localparam logic [1:0] A_SRC_ZERO = 2'd2;

  localparam logic [1:0] B_SRC_RS2  = 2'd0;
  localparam logic [1:0] B_SRC_IMM  = 2'd1;
  localparam logic [1:0] B_SRC_FOUR = 2'd2;

  localparam logic [1:0] ALS_ARITH = 2'd0;
  localparam logic [1:0] ALS_LOGIC = 2'd1;
  localparam logic [1:0] ALS_SHIFT = 2'd2;
  localparam logic [1:0] ALS_CMP   = 2'd3;

  localparam logic [1:0] S_ADD  = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_AND  = 2'd0;
  localparam logic [1:0] S_OR   = 2'd1;
  localparam logic [1:0] S_XOR  = 2'd2;
  localparam logic [1:0] S_SLL  = 2'd0;
  localparam logic [1:0] S_SRL  = 2'd1;
  localparam logic [1:0] S_SRA  = 2'd2;
  localparam logic [1:0] S_SLT  = 2'd0;
  localparam logic [1:0] S_SLTU = 2'd1;

  localparam logic [2:0] O_ALU    = 3'd0;
  localparam logic [2:0] O_LOAD   = 3'd1;
  localparam logic [2:0] O_STORE  = 3'd2;
  localparam logic [2:0] O_BRANCH = 3'd3;
  localparam logic [2:0] O_LINK   = 3'd4;
  localparam logic [2:0] O_NONE   = 3'd5;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [IMM_MAX_W-1:0] imm;
    logic [2:0]           format;
    logic                 subformat;
    logic [1:0]           a;
    logic [1:0]           b;
    logic [1:0]           als;
    logic [1:0]           s;
    logic [2:0]           o;
    logic                 j;
    logic                 exc;
  } decoded_t;

  // Idle entry: everything cleared, result routing parked on "none".
  function automatic decoded_t decoded_rst();
    decoded_t d;
    d   = '0;
    d.o = O_NONE;
    return d;
  endfunction

  // {ALS, S} for the OP/OP-IMM funct3 space; alt selects sub/sra.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    r = {ALS_ARITH, S_ADD};
    case (f3)
      3'd0:    r = alt ? {ALS_ARITH, S_SUB} : {ALS_ARITH, S_ADD};
      3'd1:    r = {ALS_SHIFT, S_SLL};
      3'd2:    r = {ALS_CMP, S_SLT};
      3'd3:    r = {ALS_CMP, S_SLTU};
      3'd4:    r = {ALS_LOGIC, S_XOR};
      3'd5:    r = alt ? {ALS_SHIFT, S_SRA} : {ALS_SHIFT, S_SRL};
      3'd6:    r = {ALS_LOGIC, S_OR};
      default: r = {ALS_LOGIC, S_AND};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_core.sv
// Purely combinational RV32I decoder: raw instruction to decoded_t.
// Illegal encodings keep only the raw opcode/funct fields and flag EXC.
module decode_core
  import kwan_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0] inst,
  output decoded_t    dec
);

  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_sel;
  logic            legal;
  logic            use_rd;
  logic            use_rs1;
  logic            use_rs2;
  logic [2:0]      fmt;
  logic            sub;
  logic [1:0]      a_src;
  logic [1:0]      b_src;
  logic [1:0]      als;
  logic [1:0]      s_op;
  logic [2:0]      o_sel;
  logic            jmp;

  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  // Per-opcode control and legality.
  always_comb begin
    legal   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    fmt     = FMT_R;
    sub     = 1'b0;
    a_src   = A_SRC_RS1;
    b_src   = B_SRC_RS2;
    als     = ALS_ARITH;
    s_op    = S_ADD;
    o_sel   = O_NONE;
    jmp     = 1'b0;
    imm_sel = '0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OPC_LUI: begin
          legal = 1'b1; use_rd = 1'b1; fmt = FMT_U; imm_sel = imm_u;
          a_src = A_SRC_ZERO; b_src = B_SRC_IMM; o_sel = O_ALU;
        end
        OPC_AUIPC: begin
          legal = 1'b1; use_rd = 1'b1; fmt = FMT_U; imm_sel = imm_u;
          a_src = A_SRC_PC; b_src = B_SRC_IMM; o_sel = O_ALU;
        end
        OPC_JAL: begin
          legal = 1'b1; use_rd = 1'b1; fmt = FMT_U; sub = 1'b1; imm_sel = imm_j;
          a_src = A_SRC_PC; b_src = B_SRC_IMM; o_sel = O_LINK; jmp = 1'b1;
        end
        OPC_JALR: begin
          legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; fmt = FMT_I; imm_sel = imm_i;
          a_src = A_SRC_RS1; b_src = B_SRC_IMM; o_sel = O_LINK; jmp = 1'b1;
        end
        OPC_BRANCH: begin
          legal = (f3[2:1] != 2'b01);
          use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_S; sub = 1'b1; imm_sel = imm_b;
          o_sel = O_BRANCH;
          // beq/bne compare by subtraction, the rest by slt/sltu.
          {als, s_op} = f3[2] ? (f3[1] ? {ALS_CMP, S_SLTU} : {ALS_CMP, S_SLT})
                              : {ALS_ARITH, S_SUB};
        end
        OPC_LOAD: begin
          legal = !((f3 == 3'd3) || (f3[2:1] == 2'b11));
          use_rd = 1'b1; use_rs1 = 1'b1; fmt = FMT_I; imm_sel = imm_i;
          b_src = B_SRC_IMM; o_sel = O_LOAD;
        end
        OPC_STORE: begin
          legal = !f3[2] && (f3[1:0] != 2'b11);
          use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_S; imm_sel = imm_s;
          b_src = B_SRC_IMM; o_sel = O_STORE;
        end
        OPC_OP_IMM: begin
          if (f3 == 3'd1)      legal = (f7 == 7'h00);
          else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
          else                 legal = 1'b1;
          use_rd = 1'b1; use_rs1 = 1'b1; fmt = FMT_I; imm_sel = imm_i;
          b_src = B_SRC_IMM; o_sel = O_ALU;
          {als, s_op} = alu_sel(f3, (f3 == 3'd5) && inst[30]);
        end
        OPC_OP: begin
          legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
          use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_R;
          o_sel = O_ALU;
          {als, s_op} = alu_sel(f3, inst[30]);
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Assemble the payload; unused register fields read as x0.
  always_comb begin
    dec        = '0;
    dec.opcode = inst[6:0];
    dec.funct3 = f3;
    dec.funct7 = f7;
    dec.o      = O_NONE;
    dec.exc    = 1'b1;
    if (legal) begin
      dec.rd        = use_rd  ? inst[11:7]  : 5'd0;
      dec.rs1       = use_rs1 ? inst[19:15] : 5'd0;
      dec.rs2       = use_rs2 ? inst[24:20] : 5'd0;
      dec.imm       = IMM_MAX_W'($signed(imm_sel));
      dec.format    = fmt;
      dec.subformat = sub;
      dec.a         = a_src;
      dec.b         = b_src;
      dec.als       = als;
      dec.s         = s_op;
      dec.o         = o_sel;
      dec.j         = jmp;
      dec.exc       = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// kwanCPU decode stage: decoder feeding a DEPTH-entry FIFO with valid/ready on both
// sides and a branch-redirect flush. Outputs present the registered head entry.
module decode_stage
  import kwan_decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      format,
  output logic            subformat,
  output logic [1:0]      A,
  output logic [1:0]      B,
  output logic [1:0]      ALS,
  output logic [1:0]      S,
  output logic [2:0]      O,
  output logic            J,
  output logic            EXC
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  decoded_t        dec;
  decoded_t        head;
  decoded_t        ent_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0] count, count_n;
  logic             push;
  logic             pop;

  decode_core #(.XLEN(XLEN)) u_core (
    .inst (inst),
    .dec  (dec)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  // Next occupancy; flush empties the FIFO after honouring any same-cycle pop.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (push) wr_ptr_n = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_n = ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_n = count + CNT_W'(1);
        2'b01:   count_n = count - CNT_W'(1);
        default: count_n = count;
      endcase
    end
  end

  // Handshake flags are registered from the next count, so full blocks even on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      in_ready  <= (count_n != CNT_W'(DEPTH));
      out_valid <= (count_n != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_mem[i] <= decoded_rst();
        pc_mem[i]  <= '0;
      end
    end else if (push) begin
      ent_mem[wr_ptr] <= dec;
      pc_mem[wr_ptr]  <= in_pc;
    end
  end

  assign head      = ent_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];
  assign opcode    = head.opcode;
  assign funct3    = head.funct3;
  assign funct7    = head.funct7;
  assign rd        = head.rd;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign imm       = head.imm[XLEN-1:0];
  assign format    = head.format;
  assign subformat = head.subformat;
  assign A         = head.a;
  assign B         = head.b;
  assign ALS       = head.als;
  assign S         = head.s;
  assign O         = head.o;
  assign J         = head.j;
  assign EXC       = head.exc;

  // Sign-extension copies above XLEN are redundant for narrow builds.
  if (XLEN < IMM_MAX_W) begin : g_imm_hi
    logic unused_imm_hi;
    assign unused_imm_hi = ^head.imm[IMM_MAX_W-1:XLEN];
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances share stimulus and are
// checked every cycle against a mnemonic-level decode model and a FIFO queue.
module tb_decode_stage;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        sub;
    logic [1:0]  a, b, als, s;
    logic [2:0]  o;
    logic        j, exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] pc = 64'h0000_0001_0000_0FFC;

  logic        rdy_a, val_a, sub_a, j_a, exc_a;
  logic [31:0] pc_a, imm_a;
  logic [6:0]  opc_a, f7_a;
  logic [2:0]  f3_a, fmt_a, o_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [1:0]  a_a, b_a, als_a, s_a;

  logic        rdy_b, val_b, sub_b, j_b, exc_b;
  logic [63:0] pc_b, imm_b;
  logic [6:0]  opc_b, f7_b;
  logic [2:0]  f3_b, fmt_b, o_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [1:0]  a_b, b_b, als_b, s_b;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  exp_t q[$];
  exp_t obs_a, obs_b, pin;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .inst(inst), .in_pc(pc[31:0]), .out_valid(val_a), .out_ready(out_ready),
    .out_pc(pc_a), .opcode(opc_a), .funct3(f3_a), .funct7(f7_a), .rd(rd_a),
    .rs1(rs1_a), .rs2(rs2_a), .imm(imm_a), .format(fmt_a), .subformat(sub_a),
    .A(a_a), .B(b_a), .ALS(als_a), .S(s_a), .O(o_a), .J(j_a), .EXC(exc_a)
  );

  decode_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .inst(inst), .in_pc(pc), .out_valid(val_b), .out_ready(out_ready),
    .out_pc(pc_b), .opcode(opc_b), .funct3(f3_b), .funct7(f7_b), .rd(rd_b),
    .rs1(rs1_b), .rs2(rs2_b), .imm(imm_b), .format(fmt_b), .subformat(sub_b),
    .A(a_b), .B(b_b), .ALS(als_b), .S(s_b), .O(o_b), .J(j_b), .EXC(exc_b)
  );

  assign obs_a = '{pc: 64'(pc_a), opcode: opc_a, funct3: f3_a, funct7: f7_a, rd: rd_a,
                   rs1: rs1_a, rs2: rs2_a, imm: 64'(imm_a), fmt: fmt_a, sub: sub_a,
                   a: a_a, b: b_a, als: als_a, s: s_a, o: o_a, j: j_a, exc: exc_a};
  assign obs_b = '{pc: pc_b, opcode: opc_b, funct3: f3_b, funct7: f7_b, rd: rd_b,
                   rs1: rs1_b, rs2: rs2_b, imm: imm_b, fmt: fmt_b, sub: sub_b,
                   a: a_b, b: b_b, als: als_b, s: s_b, o: o_b, j: j_b, exc: exc_b};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return "add";
      3'd1: return "sll";
      3'd2: return "slt";
      3'd3: return "sltu";
      3'd4: return "xor";
      3'd5: return "srl";
      3'd6: return "or";
      default: return "and";
    endcase
  endfunction

  // Reference decode: classify the instruction, name its ALU operation, then map.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] p);
    exp_t        e;
    string       op;
    logic        ok, urd, urs1, urs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    f3 = w[14:12]; f7 = w[31:25];
    e = '0; e.pc = p; e.opcode = w[6:0]; e.funct3 = f3; e.funct7 = f7;
    ok = 1'b1; urd = 1'b0; urs1 = 1'b0; urs2 = 1'b0; op = "add";
    case (w[6:0])
      7'h37: begin e.fmt = 3; e.imm = 64'($signed({w[31:12], 12'b0})); e.a = 2; e.b = 1; e.o = 0; urd = 1; end
      7'h17: begin e.fmt = 3; e.imm = 64'($signed({w[31:12], 12'b0})); e.a = 1; e.b = 1; e.o = 0; urd = 1; end
      7'h6f: begin
        e.fmt = 3; e.sub = 1; e.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        e.a = 1; e.b = 1; e.j = 1; e.o = 4; urd = 1;
      end
      7'h67: begin e.fmt = 1; e.imm = 64'($signed(w[31:20])); e.a = 0; e.b = 1; e.j = 1; e.o = 4; urd = 1; urs1 = 1; end
      7'h63: begin
        e.fmt = 2; e.sub = 1; e.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        e.o = 3; urs1 = 1; urs2 = 1;
        if (f3 == 2 || f3 == 3) ok = 0;
        op = (f3 < 4) ? "sub" : ((f3 >= 6) ? "sltu" : "slt");
      end
      7'h03: begin
        e.fmt = 1; e.imm = 64'($signed(w[31:20])); e.b = 1; e.o = 1; urd = 1; urs1 = 1;
        if (f3 == 3 || f3 == 6 || f3 == 7) ok = 0;
      end
      7'h23: begin
        e.fmt = 2; e.imm = 64'($signed({w[31:25], w[11:7]})); e.b = 1; e.o = 2; urs1 = 1; urs2 = 1;
        if (f3 > 2) ok = 0;
      end
      7'h13: begin
        e.fmt = 1; e.imm = 64'($signed(w[31:20])); e.b = 1; e.o = 0; urd = 1; urs1 = 1;
        op = base_op(f3);
        if (f3 == 1 && f7 != 0) ok = 0;
        if (f3 == 5) begin
          if (f7 == 7'h20) op = "sra";
          else if (f7 != 0) ok = 0;
        end
      end
      7'h33: begin
        e.fmt = 0; e.o = 0; urd = 1; urs1 = 1; urs2 = 1;
        op = base_op(f3);
        if (f7 == 7'h20) begin
          if (f3 == 0) op = "sub";
          else if (f3 == 5) op = "sra";
          else ok = 0;
        end else if (f7 != 0) ok = 0;
      end
      default: ok = 0;
    endcase
    if (w[1:0] != 2'b11) ok = 0;
    case (op)
      "sub":  begin e.als = 0; e.s = 1; end
      "and":  begin e.als = 1; e.s = 0; end
      "or":   begin e.als = 1; e.s = 1; end
      "xor":  begin e.als = 1; e.s = 2; end
      "sll":  begin e.als = 2; e.s = 0; end
      "srl":  begin e.als = 2; e.s = 1; end
      "sra":  begin e.als = 2; e.s = 2; end
      "slt":  begin e.als = 3; e.s = 0; end
      "sltu": begin e.als = 3; e.s = 1; end
      default: begin e.als = 0; e.s = 0; end
    endcase
    if (urd)  e.rd  = w[11:7];
    if (urs1) e.rs1 = w[19:15];
    if (urs2) e.rs2 = w[24:20];
    if (!ok) begin
      e = '0; e.pc = p; e.opcode = w[6:0]; e.funct3 = f3; e.funct7 = f7;
      e.o = 5; e.exc = 1;
    end
    return e;
  endfunction

  function automatic exp_t trunc32(input exp_t e);
    exp_t t;
    t = e;
    t.pc  = {32'b0, e.pc[31:0]};
    t.imm = {32'b0, e.imm[31:0]};
    return t;
  endfunction

  // FIFO model, advanced on the same edges as the DUTs.
  always @(posedge clk or posedge rst) begin
    bit pop_m, push_m;
    if (rst) begin
      q.delete();
    end else begin
      pop_m  = (q.size() != 0) && out_ready;
      push_m = in_valid && (q.size() != DEPTH) && !flush;
      if (flush) q.delete();
      else begin
        if (pop_m)  void'(q.pop_front());
        if (push_m) q.push_back(ref_decode(inst, pc));
      end
    end
  end

  // Every-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("out_valid32", 256'(val_a), 256'(q.size() != 0));
      chk("out_valid64", 256'(val_b), 256'(q.size() != 0));
      chk("in_ready32", 256'(rdy_a), 256'(q.size() != DEPTH));
      chk("in_ready64", 256'(rdy_b), 256'(q.size() != DEPTH));
      if (q.size() != 0) begin
        chk("head32", 256'(obs_a), 256'(trunc32(q[0])));
        chk("head64", 256'(obs_b), 256'(q[0]));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    in_valid = v; inst = w; out_ready = ordy; flush = fl; pc = pc + 64'd4;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  opcs [9];
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 8)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    chk("model_addi_imm", ref_decode(32'hff010113, 64'd0).imm, 64'hFFFF_FFFF_FFFF_FFF0);
    pin = ref_decode(32'h40001033, 64'd0);
    chk("model_bad_op", {pin.exc, pin.o, pin.rd}, {1'b1, 3'd5, 5'd0});

    chk("rst_valid", 256'(val_a), 256'(0));
    chk("rst_ready", 256'(rdy_b), 256'(1));
    chk("rst_O", 256'(o_a), 256'(5));
    chk("rst_fields", 256'({exc_b, imm_b, rd_b, fmt_b, pc_b}), 256'(0));

    drive(1, 32'hff010113, 1, 0);
    chk("addi_valid", 256'(val_a), 256'(1));
    chk("addi_regs", {rd_a, rs1_a, rs2_a}, {5'd2, 5'd2, 5'd0});
    chk("addi_imm32", 256'(imm_a), 256'(32'hFFFF_FFF0));
    chk("addi_imm64", 256'(imm_b), 256'(64'hFFFF_FFFF_FFFF_FFF0));
    chk("addi_ctl", {fmt_a, a_a, b_a, als_a, s_a, o_a, exc_a}, {3'd1, 2'd0, 2'd1, 2'd0, 2'd0, 3'd0, 1'b0});
    chk("addi_pc32", 256'(pc_a), 256'(32'h1000));

    drive(1, 32'h00812623, 1, 0);
    chk("sw_fields", {fmt_a, rs1_a, rs2_a, imm_a, o_a}, {3'd2, 5'd2, 5'd8, 32'd12, 3'd2});
    drive(1, 32'h00008067, 1, 0);
    chk("ret_fields", {j_a, rs1_a, rd_a, imm_b, o_b}, {1'b1, 5'd1, 5'd0, 64'd0, 3'd4});
    drive(0, 32'h0, 1, 0);

    // Back-pressure: two accepts fill the FIFO, third waits.
    drive(1, 32'h00100093, 0, 0);
    chk("bp_ready1", 256'(rdy_a), 256'(1));
    drive(1, 32'h00200113, 0, 0);
    chk("bp_full", 256'(rdy_a), 256'(0));
    drive(1, 32'h00300193, 0, 0);
    chk("bp_hold_rd", 256'(rd_a), 256'(1));
    drive(1, 32'h00300193, 1, 0);
    chk("bp_ready_back", 256'(rdy_a), 256'(1));
    chk("bp_order2", 256'(rd_a), 256'(2));
    drive(1, 32'h00300193, 1, 0);
    chk("bp_order3", 256'(rd_a), 256'(3));
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);

    // Flush: full FIFO, then one entry with a same-cycle push.
    drive(1, 32'h00100093, 0, 0);
    drive(1, 32'h00200113, 0, 0);
    drive(1, 32'h00400213, 0, 1);
    chk("flush_valid", 256'(val_a), 256'(0));
    chk("flush_ready", 256'(rdy_b), 256'(1));
    drive(1, 32'h00100093, 0, 0);
    drive(1, 32'h00400213, 1, 1);
    chk("flush_drop", 256'(val_b), 256'(0));
    drive(0, 32'h0, 1, 0);
    chk("flush_stays_empty", 256'(val_a), 256'(0));

    // Illegal encodings.
    drive(1, 32'h00000000, 1, 0);
    chk("ill_zero", {exc_a, o_a, rd_a}, {1'b1, 3'd5, 5'd0});
    drive(1, 32'h40001033, 1, 0);
    chk("ill_op_f7", {exc_b, o_b, rd_b}, {1'b1, 3'd5, 5'd0});
    drive(1, 32'h400011b3, 1, 0);
    chk("ill_rd_forced", {exc_a, o_a, rd_a}, {1'b1, 3'd5, 5'd0});
    drive(0, 32'h0, 1, 0);

    // Asynchronous reset with two entries buffered.
    drive(1, 32'h00100093, 0, 0);
    drive(1, 32'h00200113, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid32", 256'(val_a), 256'(0));
    chk("arst_valid64", 256'(val_b), 256'(0));
    chk("arst_ready", 256'(rdy_a), 256'(1));
    chk("arst_fields", {o_b, exc_b, rd_b, imm_b}, {3'd5, 1'b0, 5'd0, 64'd0});
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
    end
    for (int n = 0; n < 4; n++) drive(0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, back-pressured instruction-decode stage for kwanCPU.
- Accepts raw 32-bit RV32I instructions with their PC and decodes them into register addresses, an XLEN-wide sign-extended immediate, format flags and ALU/PC control signals.
- Results are buffered in a DEPTH-entry FIFO and released to execute over a valid/ready handshake.
- Supports a pipeline flush for branch redirect.

Parameters:
- XLEN, 32: register/immediate/PC width. Legal values are 32 and 64.
- DEPTH, 2: number of decoded-entry FIFO slots. Must be ≥1; need not be a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all buffered entries and the same-cycle input
- in_valid  in  1  inst/in_pc valid
- in_ready  out  1  stage can accept an instruction
- inst  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  execute accepts head entry
- out_pc  out  XLEN  PC of head entry
- opcode  out  7  inst[6:0]
- funct3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]
- rd, rs1, rs2  out  5 each  register addresses. Forced to 0 when the format does not use the field.
- imm  out  XLEN  sign-extended immediate
- format  out  3  0=R, 1=I, 2=S, 3=U
- subformat  out  1  B (with S) or J (with U)
- A  out  2  ALU A source: 0=rs1, 1=pc, 2=zero
- B  out  2  ALU B source: 0=rs2, 1=imm, 2=const 4
- ALS  out  2  0=arith, 1=logic, 2=shift, 3=compare
- S  out  2  op within class
  - arith: 0=add, 1=sub
  - logic: 0=and, 1=or, 2=xor
  - shift: 0=sll, 1=srl, 2=sra
  - compare: 0=slt, 1=sltu
- O  out  3  result routing: 0=ALU→rd, 1=load→rd, 2=store, 3=branch, 4=link(pc+4)→rd, 5=none
- J  out  1  unconditional PC load (JAL/JALR)
- EXC  out  1  illegal instruction

Behaviour:
- Decode is combinational from inst. An entry is written to the FIFO tail when in_valid & in_ready & !flush.
- Latency: an instruction accepted in cycle N appears at out_valid in cycle N+1, provided all older entries have drained. There is no combinational in→out path.
- Pop condition: out_valid & out_ready pops the head.
- Occupancy counter: width $clog2(DEPTH+1). Push and pop in the same cycle leave the count unchanged.
- Pointer wrap: read/write pointers wrap from DEPTH-1 to 0.
- in_ready = (count != DEPTH), driven from the registered count.
  - When full, in_ready=0 even if a pop occurs that cycle (no pass-through when full).
- out_valid = (count != 0). Output fields reflect the head entry and hold stable while out_valid & !out_ready.
- flush:
  - Next cycle: count=0, pointers=0, out_valid=0.
  - A pop in the flush cycle is still honoured by execute.
  - A push in the flush cycle is dropped.
- Reset (asynchronous, at any time including mid-transfer):
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - Every registered output field = 0, except EXC=0 and O=5.
- Immediates, sign bit inst[31] replicated to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - LUI: A=2, B=1, add
  - AUIPC: A=1, B=1, add
  - JAL: A=1, B=1, J=1, O=4
  - JALR: A=0, B=1, J=1, O=4
- EXC=1 for any of the following; when set, rd is forced to 0 and O=5:
  - any other opcode, or inst[1:0] != 2'b11
  - OP with funct7 ∉ {0x00, 0x20}, or 0x20 with funct3 ∉ {0, 5}
  - shift-immediate with illegal imm[11:5]
  - funct3 reserved for branch/load/store
- XLEN=64: the RV32I decode set is unchanged; only imm/out_pc widen.

Decomposition:
- Package kwan_decode_pkg: FMT_*, A_SRC_*, B_SRC_*, ALS_*, S_*, O_* constants, opcode constants, and a packed struct decoded_t holding all decoded fields.
- Sub-module decode_core: the purely combinational inst→decoded_t decoder, parameterised by XLEN.
- decode_stage contains only the FIFO, the handshake and flush/reset logic.

Test Plan:
- Reset then push 0xff010113 (addi sp,sp,-16) with out_ready=1 → next cycle out_valid=1, rd=2, rs1=2, imm=0xFFFFFFF0, format=1, A=0, B=1, ALS=0, S=0, O=0, EXC=0.
- Push 0x00812623 (sw s0,12(sp)), then 0x00008067 (ret) → first output: format=2, rs1=2, rs2=8, imm=12, O=2. Second output: J=1, rs1=1, rd=0, imm=0, O=4.
- out_ready=0, push 3 instructions back-to-back at DEPTH=2 → in_ready falls after 2 accepts. Then out_ready=1 → outputs drain in order, in_ready returns the cycle after the first pop.
- Fill to 2 entries and assert flush together with in_valid → next cycle out_valid=0, count=0, the flushed-cycle input never appears.
- Push 0x00000000 and 0x40001033 (funct7=0x20, funct3=1) → both emerge with EXC=1, O=5, rd=0.
- Assert rst asynchronously mid-cycle with 2 entries buffered → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge. Repeat the test with XLEN=64: addi -16 gives imm=0xFFFFFFFFFFFFFFF0.
